spi_axi_burst_sequencer: RTL

Parametrised command sequencer between the SPI slave front end and the AXI-Lite master engine, in core_clk domain. It accepts a single-address or multi-beat read/write command, issues one AXI transaction per beat with auto-incrementing address, and streams write data in and read data out. Each beat has its own timeout, AXI errors are reported as sticky status, and a sustained chip-select release aborts the command.

---
 rtl/spi_axi_burst_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_axi_burst_sequencer.sv
// Purpose: turns one SPI-side read/write command (single or multi-beat) into one
//   AXI-Lite master transaction per beat, with per-beat timeout, sticky status and abort.
// Latency: first init pulse one cycle after accept; each read beat takes 3 cycles plus the AXI response time.
// Backpressure: cmd_ready only in IDLE; wdata_ready only while waiting for a write word; rdata has none.
//
// Ports:
//   core_clk, core_reset_n       clock, asynchronous active-low reset
//   core_cs_n                    synchronised SPI chip select (held high too long = abort)
//   cmd_*                        command request {write, addr, len = beats-1}
//   wdata/_valid/_ready          write-word handshake
//   rdata, rdata_valid           read word, one-cycle strobe per completed read beat
//   init_*/user_*/done_*/error_* AXI-Lite master engine interface
//   err_clear                    clears sticky status
//   status_busy, status_err      busy flag, sticky {abort, timeout, axi_err}
//
// Build option: SPI_AXI_SEQ_ADDR_INC_EN -- when defined, the address advances by one
//   data word per beat (wrapping); when undefined, every beat reuses the command address.

module spi_axi_burst_sequencer #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 4,
  parameter int TIMEOUT_WIDTH = 5,
  parameter int ABORT_CYCLES  = 16
) (
  input  logic                  core_clk,
  input  logic                  core_reset_n,
  input  logic                  core_cs_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  init_w_axi_txn,
  output logic                  init_r_axi_txn,
  output logic [ADDR_WIDTH-1:0] user_awaddr,
  output logic [ADDR_WIDTH-1:0] user_araddr,
  output logic [DATA_WIDTH-1:0] user_wdata,
  input  logic [DATA_WIDTH-1:0] user_rdata,
  input  logic                  done_w_axi_txn,
  input  logic                  done_r_axi_txn,
  input  logic                  error_w_axi_txn,
  input  logic                  error_r_axi_txn,
  input  logic                  err_clear,
  output logic                  status_busy,
  output logic [2:0]            status_err
);

  localparam int ACNT_W = $clog2(ABORT_CYCLES + 1);
  // Last WAIT-cycle count value (2^W - 2): if no done arrives while the counter holds
  // this value, the next increment would reach the terminal count, so the beat times out.
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE, W_DATA, W_ISSUE, W_SETTLE, W_WAIT, R_ISSUE, R_SETTLE, R_WAIT
  } state_t;

  state_t                  state;
  logic [LEN_WIDTH-1:0]    beats_left;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [ACNT_W-1:0]       abort_cnt;
  logic                    abort_hit;
  logic                    set_axi;
  logic                    set_tmo;
  logic [ADDR_WIDTH-1:0]   awaddr_next;
  logic [ADDR_WIDTH-1:0]   araddr_next;

`ifdef SPI_AXI_SEQ_ADDR_INC_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  // Natural overflow of the add gives the modulo-2^ADDR_WIDTH wrap.
  assign awaddr_next = user_awaddr + ADDR_STEP;
  assign araddr_next = user_araddr + ADDR_STEP;
`else
  // Fixed-address bursts (FIFO ports): the latched command address is reused.
  assign awaddr_next = user_awaddr;
  assign araddr_next = user_araddr;
`endif

  // This cycle is the ABORT_CYCLES-th consecutive high chip-select cycle of a command.
  assign abort_hit = (state != IDLE) && core_cs_n &&
                     (abort_cnt == ACNT_W'(ABORT_CYCLES - 1));

  assign cmd_ready   = (state == IDLE);
  assign status_busy = (state != IDLE);
  // Withheld on the abort cycle so an aborted command never swallows a word.
  assign wdata_ready = (state == W_DATA) && !abort_hit;

  // Status events of this cycle; abort overrides a same-cycle done or timeout.
  always_comb begin
    set_axi = 1'b0;
    set_tmo = 1'b0;
    if (!abort_hit) begin
      if (state == W_WAIT) begin
        if (done_w_axi_txn)         set_axi = error_w_axi_txn;
        else if (tmo_cnt == TO_LAST) set_tmo = 1'b1;
      end
      if (state == R_WAIT) begin
        if (done_r_axi_txn)         set_axi = error_r_axi_txn;
        else if (tmo_cnt == TO_LAST) set_tmo = 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state          <= IDLE;
      beats_left     <= '0;
      tmo_cnt        <= '0;
      abort_cnt      <= '0;
      user_awaddr    <= '0;
      user_araddr    <= '0;
      user_wdata     <= '0;
      rdata          <= '0;
      rdata_valid    <= 1'b0;
      init_w_axi_txn <= 1'b0;
      init_r_axi_txn <= 1'b0;
      status_err     <= '0;
    end else begin
      rdata_valid    <= 1'b0;
      init_w_axi_txn <= 1'b0;
      init_r_axi_txn <= 1'b0;

      // A set in the same cycle as a clear survives.
      status_err <= (err_clear ? 3'b000 : status_err) | {abort_hit, set_tmo, set_axi};

      if ((state == IDLE) || !core_cs_n || abort_hit)
        abort_cnt <= '0;
      else
        abort_cnt <= abort_cnt + 1'b1;

      if (abort_hit) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              beats_left <= cmd_len;
              if (cmd_write) begin
                user_awaddr <= cmd_addr;
                state       <= W_DATA;
              end else begin
                user_araddr    <= cmd_addr;
                init_r_axi_txn <= 1'b1;
                state          <= R_ISSUE;
              end
            end
          end
          W_DATA: begin
            if (wdata_valid) begin
              user_wdata     <= wdata;
              init_w_axi_txn <= 1'b1;
              state          <= W_ISSUE;
            end
          end
          W_ISSUE:  state <= W_SETTLE;
          // Settle cycle lets the engine drop done from the previous transaction.
          W_SETTLE: begin
            tmo_cnt <= '0;
            state   <= W_WAIT;
          end
          W_WAIT: begin
            if (done_w_axi_txn) begin
              if (beats_left == '0) begin
                state <= IDLE;
              end else begin
                beats_left  <= beats_left - 1'b1;
                user_awaddr <= awaddr_next;
                state       <= W_DATA;
              end
            end else if (tmo_cnt == TO_LAST) begin
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          R_ISSUE:  state <= R_SETTLE;
          R_SETTLE: begin
            tmo_cnt <= '0;
            state   <= R_WAIT;
          end
          R_WAIT: begin
            if (done_r_axi_txn) begin
              rdata       <= user_rdata;
              rdata_valid <= 1'b1;
              if (beats_left == '0) begin
                state <= IDLE;
              end else begin
                beats_left     <= beats_left - 1'b1;
                user_araddr    <= araddr_next;
                init_r_axi_txn <= 1'b1;
                state          <= R_ISSUE;
              end
            end else if (tmo_cnt == TO_LAST) begin
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
